// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-port (fetch/data) arbiter onto one shared memory port
//
// Optional feature macro: MEM_ARB_TIMEOUT_EN (BUSY timeout with err pulse)
//
// Ports:
//   clk_in, reset                    clock, asynchronous active-low reset
//   if_req, if_addr                  fetch request (held until if_ack) and address
//   if_rdata, if_ack                 registered fetch data, one-cycle completion pulse
//   dm_cs, dm_r, dm_w                data chip select, read and write strobes
//   dm_addr, dm_wdata                data address and write data
//   dm_rdata, dm_ack                 registered read data, one-cycle completion pulse
//   mem_req, mem_we                  shared-memory request and write enable
//   mem_addr, mem_wdata              shared-memory address and write data
//   mem_rdata, mem_ready             shared-memory read data and completion
//   stall                            CPU hold while any request is unacknowledged
//   err                              timeout pulse, coincident with the ack
module mem_arbiter #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk_in,
    input  logic        reset,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_ack,
    input  logic        dm_cs,
    input  logic        dm_r,
    input  logic        dm_w,
    input  logic [31:0] dm_addr,
    input  logic [31:0] dm_wdata,
    output logic [31:0] dm_rdata,
    output logic        dm_ack,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready,
    output logic        stall,
    output logic        err
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        IF_BUSY = 2'd1,
        DM_BUSY = 2'd2,
        RESP    = 2'd3
    } state_t;

    state_t state;
    state_t state_nxt;

    logic dm_req;
    logic grant_dm;
    logic busy;
    logic last_dm;   // 1: most recent grant went to the data port
    logic we_q;
    logic tmo;       // BUSY expired without mem_ready this cycle

    assign dm_req = dm_cs & (dm_r | dm_w);
    assign busy   = (state == IF_BUSY) || (state == DM_BUSY);

    // Data wins a collision unless it also won the previous grant.
    assign grant_dm = dm_req & (~if_req | ~last_dm);

    assign stall = (if_req & ~if_ack) | (dm_req & ~dm_ack);

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [TW-1:0] tmr;
    logic          err_q;

    // tmr holds the number of completed BUSY cycles, so the last allowed
    // cycle is the one where tmr reaches TIMEOUT_CYCLES-1.
    assign tmo = busy & ~mem_ready & (tmr == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            tmr   <= '0;
            err_q <= 1'b0;
        end else begin
            if (busy) begin
                tmr   <= tmr + TW'(1);
                err_q <= tmo;
            end else begin
                tmr   <= '0;
            end
        end
    end

    assign err = (state == RESP) & err_q;
`else
    assign tmo = 1'b0;
    assign err = 1'b0;
`endif

    // State register
    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (grant_dm) begin
                    state_nxt = DM_BUSY;
                end else if (if_req) begin
                    state_nxt = IF_BUSY;
                end
            end
            IF_BUSY, DM_BUSY: begin
                if (mem_ready || tmo) begin
                    state_nxt = RESP;
                end
            end
            RESP: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Outputs decoded from state; the granted port in RESP is last_dm.
    always_comb begin
        mem_req = busy;
        mem_we  = (state == DM_BUSY) & we_q;
        if_ack  = (state == RESP) & ~last_dm;
        dm_ack  = (state == RESP) & last_dm;
    end

    // Transaction latches and read-data capture
    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            last_dm   <= 1'b0;
            we_q      <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            if_rdata  <= '0;
            dm_rdata  <= '0;
        end else begin
            if (state == IDLE && state_nxt != IDLE) begin
                last_dm <= grant_dm;
                if (grant_dm) begin
                    mem_addr  <= dm_addr;
                    mem_wdata <= dm_wdata;
                    we_q      <= dm_w;      // write wins over a simultaneous read
                end else begin
                    mem_addr  <= if_addr;
                    we_q      <= 1'b0;
                end
            end
            if (busy && (mem_ready || tmo)) begin
                if (last_dm) begin
                    dm_rdata <= tmo ? 32'hDEADBEEF : mem_rdata;
                end else begin
                    if_rdata <= tmo ? 32'hDEADBEEF : mem_rdata;
                end
            end
        end
    end

endmodule
